// File: rtl/mem_addr_pkg.sv
// Shared types and encodings for the memory-address unit: FSM states,
// access-size codes and well-known source indices.
package mem_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10,
    ST_ERR    = 2'b11
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is also treated as word

  localparam int SRC_PC = 0;

endpackage

// File: rtl/addr_align_chk.sv
// Combinational alignment check on the two address LSBs for a given access size.
// Only instantiated when ADDR_ALIGN_CHECK_EN is defined.
module addr_align_chk
  import mem_addr_pkg::*;
(
  input  logic [1:0] addr_lsb_i,
  input  logic [1:0] size_i,
  output logic       misaligned_o
);

  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      SIZE_BYTE: misaligned_o = 1'b0;
      SIZE_HALF: misaligned_o = addr_lsb_i[0];
      default:   misaligned_o = |addr_lsb_i;
    endcase
  end

endmodule

// File: rtl/mem_addr_unit.sv
// Memory-address unit: source mux, address/size capture and request/ready FSM with
// wait-cycle timeout. Optional alignment fault checking under ADDR_ALIGN_CHECK_EN.
module mem_addr_unit
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int N_SRC    = 4,
  parameter int WAIT_MAX = 15,
  localparam int SEL_W   = $clog2(N_SRC),
  localparam int CNT_W   = $clog2(WAIT_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_SRC*ADDR_W-1:0] src_addr_i,
  input  logic [SEL_W-1:0]        src_sel_i,
  input  logic [1:0]              size_i,
  input  logic                    start_i,
  input  logic                    mem_ready_i,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [1:0]              mem_size_o,
  output logic                    mem_req_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    timeout_o,
  output logic                    bad_sel_o,
  output logic                    misaligned_o
);

  localparam logic [SEL_W:0]   N_SRC_V  = (SEL_W + 1)'(N_SRC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               bad_sel_q, bad_sel_d;
  logic               misal_q, misal_d;

  logic [ADDR_W-1:0]  src_arr [N_SRC];
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_valid;
  logic               align_fault;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_arr[gi] = src_addr_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Out-of-range selectors fall through to zero rather than aliasing a source.
  assign sel_valid = ({1'b0, src_sel_i} < N_SRC_V);

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if ({1'b0, src_sel_i} == (SEL_W + 1)'(i)) sel_addr = src_arr[i];
    end
  end

`ifdef ADDR_ALIGN_CHECK_EN
  addr_align_chk u_align_chk (
    .addr_lsb_i   (sel_addr[1:0]),
    .size_i       (size_i),
    .misaligned_o (align_fault)
  );
`else
  assign align_fault = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    bad_sel_d = bad_sel_q;
    misal_d   = misal_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d = sel_addr;
          size_d = size_i;
          cnt_d  = '0;
          if (!sel_valid) begin
            state_d   = ST_ERR;
            bad_sel_d = 1'b1;
          end else if (align_fault) begin
            state_d = ST_ERR;
            misal_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // Ready on the last permitted cycle still completes the access.
        if (mem_ready_i) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        state_d   = ST_IDLE;
        timeout_d = 1'b0;
        bad_sel_d = 1'b0;
        misal_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      bad_sel_q <= 1'b0;
      misal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      bad_sel_q <= bad_sel_d;
      misal_q   <= misal_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_size_o   = size_q;
  assign mem_req_o    = (state_q == ST_ACCESS);
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = (state_q == ST_ERR);
  assign timeout_o    = timeout_q;
  assign bad_sel_o    = bad_sel_q;
  assign misaligned_o = misal_q;

endmodule
